// File: rtl/instruction_fetch_pkg.sv
// Shared CPU constants for the fetch stage and its neighbours.
// Holds the bubble encoding, the opcode map the decoder relies on and the
// default PC width.
package instruction_fetch_pkg;
  localparam int          CPU_PC_WIDTH = 32;
  localparam logic [31:0] CPU_NOP_WORD = 32'hF000_0000;

  localparam logic [5:0] OPC_RTYPE = 6'b101010;
  localparam logic [5:0] OPC_VBNZ  = 6'b100010;
  localparam logic [5:0] OPC_VBENZ = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b100000;
  localparam logic [5:0] OPC_LW    = 6'b100001;
  localparam logic [5:0] OPC_NOP   = 6'b111100;
endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: hazard/branch controls in, instruction memory port, and
// the IF/ID register outputs to the decoder.
//   master : the fetch unit (drives imem_addr/imem_rd_en and if_id_*)
//   slave  : the environment (HDU, branch logic, memory, decoder)
interface instruction_fetch_if #(
  parameter int PC_WIDTH = 32
);
  logic                stall;
  logic                branch_taken;
  logic [PC_WIDTH-1:0] branch_target;
  logic [PC_WIDTH-1:0] imem_addr;
  logic                imem_rd_en;
  logic [31:0]         imem_rdata;
  logic [31:0]         if_id_instr;
  logic [PC_WIDTH-1:0] if_id_pc;
  logic                if_id_valid;

  modport master (
    input  stall, branch_taken, branch_target, imem_rdata,
    output imem_addr, imem_rd_en, if_id_instr, if_id_pc, if_id_valid
  );

  modport slave (
    output stall, branch_taken, branch_target, imem_rdata,
    input  imem_addr, imem_rd_en, if_id_instr, if_id_pc, if_id_valid
  );
endinterface

// File: rtl/instruction_fetch_skid_buffer.sv
// One-entry holding register for a fetched word (instr + pc) that arrived
// while IF/ID could not accept it.
//   clk, reset_n : clock, async active-low reset
//   i_clr        : discard contents (redirect); highest priority
//   i_load       : capture i_instr/i_pc, entry becomes valid
//   i_drain      : entry consumed by IF/ID, becomes empty
//   o_valid/o_instr/o_pc : current contents
module instruction_fetch_skid_buffer #(
  parameter int PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_clr,
  input  logic                i_load,
  input  logic [31:0]         i_instr,
  input  logic [PC_WIDTH-1:0] i_pc,
  input  logic                i_drain,
  output logic                o_valid,
  output logic [31:0]         o_instr,
  output logic [PC_WIDTH-1:0] o_pc
);
  logic                r_valid;
  logic [31:0]         r_instr;
  logic [PC_WIDTH-1:0] r_pc;

  // Load beats drain: draining to IF/ID while a new word arrives refills it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;
endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives a 1-cycle-latency instruction memory and
// registers the IF/ID word for the decoder. Stalls hold IF/ID and the PC;
// a branch redirects the PC, flushes IF/ID and squashes the outstanding read.
//   clk, reset_n : clock, async active-low reset
//   bus (master) : stall/branch inputs, imem port, if_id_* outputs
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int                PC_WIDTH = CPU_PC_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter logic [31:0]       NOP_WORD = CPU_NOP_WORD
) (
  input logic                 clk,
  input logic                 reset_n,
  instruction_fetch_if.master bus
);
  logic [PC_WIDTH-1:0] r_fetch_pc, r_req_pc, r_if_id_pc;
  logic                r_req_valid, r_squash, r_if_id_valid;
  logic [31:0]         r_if_id_instr;

  logic                w_rd_en, w_arrive, w_skid_load, w_skid_drain;
  logic                w_skid_valid;
  logic [31:0]         w_skid_instr;
  logic [PC_WIDTH-1:0] w_skid_pc;

  // No new read while the skid is full, so at most one word is ever parked.
  assign w_rd_en  = reset_n & ~bus.stall & ~w_skid_valid;
  assign w_arrive = r_req_valid & ~r_squash;

  // The arriving word parks in the skid when IF/ID is held, or when IF/ID is
  // busy taking the older skid word (keeps program order).
  assign w_skid_load  = w_arrive & (bus.stall | w_skid_valid);
  assign w_skid_drain = ~bus.stall & w_skid_valid;

  instruction_fetch_skid_buffer #(.PC_WIDTH(PC_WIDTH)) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (bus.branch_taken),
    .i_load  (w_skid_load),
    .i_instr (bus.imem_rdata),
    .i_pc    (r_req_pc),
    .i_drain (w_skid_drain),
    .o_valid (w_skid_valid),
    .o_instr (w_skid_instr),
    .o_pc    (w_skid_pc)
  );

  // PC and in-flight request tracking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_pc  <= RESET_PC;
      r_req_valid <= 1'b0;
      r_req_pc    <= '0;
      r_squash    <= 1'b0;
    end else begin
      r_req_valid <= w_rd_en;
      if (w_rd_en) r_req_pc <= r_fetch_pc;
      if (bus.branch_taken)  r_fetch_pc <= bus.branch_target;
      else if (w_rd_en)      r_fetch_pc <= r_fetch_pc + PC_WIDTH'(4);
      // A read issued on the branch cycle returns next cycle; drop it.
      r_squash <= bus.branch_taken & (w_rd_en | r_req_valid);
    end
  end

  // IF/ID register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_if_id_instr <= NOP_WORD;
      r_if_id_pc    <= '0;
      r_if_id_valid <= 1'b0;
    end else if (bus.branch_taken) begin
      r_if_id_instr <= NOP_WORD;
      r_if_id_pc    <= '0;
      r_if_id_valid <= 1'b0;
    end else if (!bus.stall) begin
      if (w_skid_valid) begin
        r_if_id_instr <= w_skid_instr;
        r_if_id_pc    <= w_skid_pc;
        r_if_id_valid <= 1'b1;
      end else if (w_arrive) begin
        r_if_id_instr <= bus.imem_rdata;
        r_if_id_pc    <= r_req_pc;
        r_if_id_valid <= 1'b1;
      end else begin
        r_if_id_instr <= NOP_WORD;
        r_if_id_valid <= 1'b0;
      end
    end
  end

  assign bus.imem_rd_en  = w_rd_en;
  assign bus.imem_addr   = r_fetch_pc;
  assign bus.if_id_instr = r_if_id_instr;
  assign bus.if_id_pc    = r_if_id_pc;
  assign bus.if_id_valid = r_if_id_valid;
endmodule
